id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 110 +++++++++++
 tb/tb_id_ex_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Priority per edge: reset, flush, stall, load-use bubble, capture.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [9:0]        id_ctrl,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [9:0]        ex_ctrl,
   output logic              load_use_stall,
   output logic [15:0]       bubble_cnt
);

   typedef enum logic [2:0] {
      ACT_RESET,
      ACT_FLUSH,
      ACT_HOLD,
      ACT_BUBBLE,
      ACT_CAPTURE
   } action_t;

   localparam int CTRL_MEMREAD = 1;

   action_t act;
   logic    ex_is_load;
   logic    rt_nonzero;
   logic    rt_match;
   logic    cnt_sat;

   // A load in EX whose destination feeds the ID instruction; $zero never creates a hazard.
   assign ex_is_load     = ex_valid & ex_ctrl[CTRL_MEMREAD];
   assign rt_nonzero     = (ex_rt != '0);
   assign rt_match       = (ex_rt == id_rs) | (ex_rt == id_rt);
   assign load_use_stall = ex_is_load & id_valid & rt_nonzero & rt_match;

   assign cnt_sat = (bubble_cnt == 16'hFFFF);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      act = ACT_CAPTURE;
      if (reset)               act = ACT_RESET;
      else if (flush)          act = ACT_FLUSH;
      else if (stall)          act = ACT_HOLD;
      else if (load_use_stall) act = ACT_BUBBLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      unique case (act)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            ex_valid <= 1'b0;
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
         end
         ACT_HOLD: begin
         end
         ACT_CAPTURE: begin
            ex_valid <= id_valid;
            ex_pc4   <= id_pc4;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            // An invalid slot must never carry side-effecting control bits.
            ex_ctrl  <= id_ctrl & {10{id_valid}};
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      unique case (act)
         ACT_RESET:             bubble_cnt <= '0;
         ACT_FLUSH, ACT_BUBBLE: if (!cnt_sat) bubble_cnt <= bubble_cnt + 16'd1;
         ACT_HOLD, ACT_CAPTURE: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus pushes expected EX state, a monitor pops and compares
// after each rising edge; load_use_stall is checked combinationally before each edge.
module tb_id_ex_reg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [9:0]        ctrl;
      logic [15:0]       cnt;
   } ex_t;

   logic              clk = 1'b0;
   logic              reset, stall, flush, id_valid;
   logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
   logic [REG_W-1:0]  id_rs, id_rt, id_rd;
   logic [9:0]        id_ctrl;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
   logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
   logic [9:0]        ex_ctrl;
   logic              load_use_stall;
   logic [15:0]       bubble_cnt;

   int  total = 0;
   int  bad   = 0;
   ex_t m     = '0;
   bit  model_init = 1'b0;
   ex_t exp_q[$];

   always #5 clk = ~clk;

   id_ex_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
      .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
   );

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: the DUT presents a new EX state after every rising edge.
   always @(posedge clk) begin
      ex_t e;
      ex_t a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, bubble_cnt};
         check("ex_state", 256'(a), 256'(e));
      end
   end

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Applies the current inputs for one edge: checks the hazard flag, predicts the next EX state.
   task automatic tick();
      ex_t  nxt;
      logic hazard;
      #1;
      hazard = m.valid && m.ctrl[1] && id_valid && (m.rt != 0) && (m.rt == id_rs || m.rt == id_rt);
      if (model_init) check("load_use_stall", 256'(load_use_stall), 256'(hazard));
      nxt = m;
      if (reset) begin
         nxt = '0;
      end else if (flush || (!stall && hazard)) begin
         nxt     = '0;
         nxt.cnt = sat_inc(m.cnt);
      end else if (!stall) begin
         nxt.valid = id_valid;
         nxt.pc4   = id_pc4;
         nxt.rd1   = id_rd1;
         nxt.rd2   = id_rd2;
         nxt.imm   = id_imm;
         nxt.rs    = id_rs;
         nxt.rt    = id_rt;
         nxt.rd    = id_rd;
         nxt.ctrl  = id_valid ? id_ctrl : 10'h000;
      end
      m = nxt;
      if (reset) model_init = 1'b1;
      exp_q.push_back(nxt);
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [9:0] ctrl);
      id_valid = v;
      id_pc4   = pc4;
      id_rd1   = $urandom;
      id_rd2   = $urandom;
      id_imm   = imm;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
      id_ctrl  = ctrl;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id(1'b1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 10'h0);
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;

      // Plain capture with a negative immediate.
      set_id(1'b1, 32'h0000_0104, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd3, 10'h021);
      tick();

      // lw into $8, then a dependent add: one bubble, then the add is captured.
      set_id(1'b1, 32'h108, 32'h4, 5'd9, 5'd8, 5'd0, 10'h063);
      tick();
      set_id(1'b1, 32'h10C, 32'h0, 5'd8, 5'd10, 5'd11, 10'h011);
      tick();
      tick();

      // Stall wins over a pending load-use for three cycles, then exactly one bubble.
      set_id(1'b1, 32'h200, 32'h0, 5'd1, 5'd12, 5'd0, 10'h063);
      tick();
      set_id(1'b1, 32'h204, 32'h0, 5'd3, 5'd12, 5'd13, 10'h011);
      stall = 1'b1;
      repeat (3) tick();
      stall = 1'b0;
      tick();
      tick();

      // Flush overrides stall.
      stall = 1'b1; flush = 1'b1;
      set_id(1'b1, 32'h300, 32'h5, 5'd4, 5'd5, 5'd6, 10'h3FF);
      tick();
      stall = 1'b0; flush = 1'b0;

      // lw targeting $zero never raises the hazard.
      set_id(1'b1, 32'h400, 32'h0, 5'd2, 5'd0, 5'd0, 10'h063);
      tick();
      set_id(1'b1, 32'h404, 32'h0, 5'd0, 5'd0, 5'd7, 10'h011);
      tick();

      // Invalid slot: control bits masked, data still captured.
      set_id(1'b0, 32'h500, 32'h1234_5678, 5'd1, 5'd2, 5'd3, 10'h3FF);
      tick();

      // Reset in the middle of a stall discards the held instruction.
      set_id(1'b1, 32'h600, 32'h0, 5'd1, 5'd14, 5'd0, 10'h063);
      tick();
      stall = 1'b1;
      set_id(1'b1, 32'h604, 32'h0, 5'd14, 5'd1, 5'd2, 10'h011);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0;
      tick();

      // Randomized traffic with a small register range to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 11) == 0);
         stall = ($urandom_range(0, 5) == 0);
         set_id($urandom_range(0, 3) != 0, $urandom, $urandom,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                10'($urandom) | ($urandom_range(0, 1) ? 10'h002 : 10'h000));
         tick();
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      // Counter saturation: 65,540 consecutive flushes from zero, then reset.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      flush = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 65540; i++) tick();
      check("bubble_cnt_saturated", 256'(bubble_cnt), 256'(16'hFFFF));
      flush = 1'b0;
      stall = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
